// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared types and defaults for the stack arbiter slice
// Optional protection feature is enabled with STACK_PROT_EN.
package stack_pkg;

  localparam int STK_DEPTH     = 1024;
  localparam int STK_DW        = 32;
  localparam int STK_BURST_MAX = 8;
  localparam int AW            = $clog2(STK_DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] bmax);
    return (len > bmax) ? bmax : len;
  endfunction

endpackage

// File: rtl/stack_arbiter_if.sv
// rtl/stack_arbiter_if.sv - CPU, context-unit and stack-side signals of the stack arbiter
// Error outputs exist only when STACK_PROT_EN is defined.
interface stack_arbiter_if #(
  parameter int DW = stack_pkg::STK_DW,
  parameter int AW = stack_pkg::AW
);
  logic          cpu_push;
  logic          cpu_pop;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;

  logic          ctx_req;
  logic          ctx_save;
  logic [3:0]    ctx_len;
  logic [DW-1:0] ctx_wdata;
  logic          ctx_wr_rdy;
  logic          ctx_rd_valid;
  logic          ctx_done;
  logic          ctx_busy;

  logic          stk_push;
  logic          stk_pop;
  logic [DW-1:0] stk_wdata;
  logic [DW-1:0] stk_rdata;
  logic          stk_rst_n;

  logic [AW-1:0] depth;
  logic          full;
  logic          empty;
`ifdef STACK_PROT_EN
  logic          err_ovf;
  logic          err_unf;
  logic          ctx_err;
`endif

  modport master (
    output cpu_push, cpu_pop, cpu_wdata, ctx_req, ctx_save, ctx_len, ctx_wdata, stk_rdata,
    input  cpu_stall, ctx_wr_rdy, ctx_rd_valid, ctx_done, ctx_busy,
    input  stk_push, stk_pop, stk_wdata, stk_rst_n, depth, full, empty
`ifdef STACK_PROT_EN
    , input err_ovf, err_unf, ctx_err
`endif
  );

  modport slave (
    input  cpu_push, cpu_pop, cpu_wdata, ctx_req, ctx_save, ctx_len, ctx_wdata, stk_rdata,
    output cpu_stall, ctx_wr_rdy, ctx_rd_valid, ctx_done, ctx_busy,
    output stk_push, stk_pop, stk_wdata, stk_rst_n, depth, full, empty
`ifdef STACK_PROT_EN
    , output err_ovf, err_unf, ctx_err
`endif
  );
endinterface

// File: rtl/stack_depth_ctr.sv
// rtl/stack_depth_ctr.sv - shadow of the stack pointer as an occupancy count
// Ops at a boundary are ignored here exactly as the stack ignores them.
module stack_depth_ctr #(
  parameter int DEPTH = 1024,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty
);
  logic inc, dec;

  assign full  = (depth == CW'(DEPTH));
  assign empty = (depth == '0);
  assign inc   = push & ~full;
  assign dec   = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (inc && !dec) begin
      depth <= depth + 1'b1;
    end else if (dec && !inc) begin
      depth <= depth - 1'b1;
    end
  end
endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - shares the single-port stack between the CPU and context SAVE/RESTORE bursts
// Define STACK_PROT_EN for overflow/underflow blocking and error flags.
module stack_arbiter
  import stack_pkg::*;
#(
  parameter int DEPTH     = STK_DEPTH,
  parameter int DW        = STK_DW,
  parameter int BURST_MAX = STK_BURST_MAX
) (
  input  logic           clk,
  input  logic           rst,
  stack_arbiter_if.slave bus
);
  localparam int         CW        = $clog2(DEPTH) + 1;
  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_SAVE    = SAVE;
  localparam logic [1:0] S_RESTORE = RESTORE;
  localparam logic [1:0] S_DRAIN   = DRAIN;
  localparam logic [3:0] BMAX      = 4'(BURST_MAX);

  logic [1:0]    state, state_nxt;
  logic [3:0]    cnt, cnt_nxt, len_c;
  logic          rd_q;
  logic          push_raw, pop_raw, push_go, pop_go;
  logic          wr_rdy, done, stall, cpu_any;
  logic [DW-1:0] wdata;
  logic [CW-1:0] depth;
  logic          full, empty;
`ifdef STACK_PROT_EN
  logic          rej_q, rej_nxt, save_abort, err_ovf_q, err_unf_q;
`endif

  assign len_c   = clamp_len(bus.ctx_len, BMAX);
  assign cpu_any = bus.cpu_push | bus.cpu_pop;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push_raw  = 1'b0;
    pop_raw   = 1'b0;
    wdata     = bus.cpu_wdata;
    wr_rdy    = 1'b0;
    done      = 1'b0;
`ifdef STACK_PROT_EN
    rej_nxt    = 1'b0;
    save_abort = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (bus.ctx_req) begin
          cnt_nxt = len_c;
          // A zero-length burst still goes through DRAIN so ctx_done lands next cycle.
          if (len_c == 4'd0) begin
            state_nxt = S_DRAIN;
          end else if (bus.ctx_save) begin
            state_nxt = S_SAVE;
`ifdef STACK_PROT_EN
          end else if (CW'(len_c) > depth) begin
            state_nxt = S_DRAIN;
            rej_nxt   = 1'b1;
`endif
          end else begin
            state_nxt = S_RESTORE;
          end
        end else begin
          push_raw = bus.cpu_push;
          pop_raw  = bus.cpu_pop & ~bus.cpu_push;
        end
      end
      S_SAVE: begin
        push_raw = 1'b1;
        wdata    = bus.ctx_wdata;
        wr_rdy   = 1'b1;
        cnt_nxt  = cnt - 4'd1;
        if (cnt == 4'd1) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
`ifdef STACK_PROT_EN
        if (full) begin
          wr_rdy     = 1'b0;
          done       = 1'b1;
          save_abort = 1'b1;
          state_nxt  = S_IDLE;
        end
`endif
      end
      S_RESTORE: begin
        pop_raw = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef STACK_PROT_EN
  assign push_go = push_raw & ~full;
  assign pop_go  = pop_raw & ~empty;
  assign stall   = (cpu_any & ((state != S_IDLE) | bus.ctx_req))
                 | ((state == S_IDLE) & ~bus.ctx_req & bus.cpu_push & full);
`else
  assign push_go = push_raw;
  assign pop_go  = pop_raw;
  assign stall   = cpu_any & ((state != S_IDLE) | bus.ctx_req);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rd_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd_q  <= pop_go & (state == S_RESTORE);
    end
  end

`ifdef STACK_PROT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rej_q     <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      rej_q     <= rej_nxt;
      err_ovf_q <= err_ovf_q | (push_raw & full);
      err_unf_q <= err_unf_q | (pop_raw & empty) | rej_nxt;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
  assign bus.ctx_err = (save_abort | ((state == S_DRAIN) & rej_q)) & ~rst;
`endif

  stack_depth_ctr #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.stk_push),
    .pop   (bus.stk_pop),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  // The stack is held in reset during rst, so nothing is issued that cycle.
  assign bus.stk_push     = push_go & ~rst;
  assign bus.stk_pop      = pop_go & ~rst;
  assign bus.stk_wdata    = wdata;
  assign bus.stk_rst_n    = ~rst;
  assign bus.cpu_stall    = stall;
  assign bus.ctx_wr_rdy   = wr_rdy & ~rst;
  assign bus.ctx_done     = done & ~rst;
  assign bus.ctx_busy     = (state != S_IDLE);
  assign bus.ctx_rd_valid = rd_q;
  assign bus.depth        = depth;
  assign bus.full         = full;
  assign bus.empty        = empty;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter against a queue-based stack model
// Build with STACK_PROT_EN defined to also cover the protection outputs.
module tb_stack_arbiter;
  localparam int DEPTH = 1024;

  typedef struct { bit care; logic [31:0] data; } rd_exp_t;
  typedef struct { bit wr; bit rd; bit err; } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] model[$];
  rd_exp_t     exp_rd[$];
  rd_exp_t     exp_cpu[$];
  done_exp_t   exp_done[$];
  bit          exp_ovf = 1'b0;
  bit          exp_unf = 1'b0;

  logic [31:0] mem [0:DEPTH-1];
  int          sp = 0;
  logic [31:0] rdata_q = '0;

  always #5 clk = ~clk;

  stack_arbiter_if #(.DW(32), .AW(11)) bus ();

  stack_arbiter #(.DEPTH(DEPTH), .DW(32), .BURST_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural single-port stack with one-cycle flopped read.
  always @(posedge clk) begin
    if (!bus.stk_rst_n) begin
      sp <= 0;
    end else if (bus.stk_push) begin
      if (sp < DEPTH) begin
        mem[sp] <= bus.stk_wdata;
        sp      <= sp + 1;
      end
    end else if (bus.stk_pop && sp > 0) begin
      rdata_q <= mem[sp-1];
      sp      <= sp - 1;
    end
  end
  assign bus.stk_rdata = rdata_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  initial begin
    bit        prev_pop;
    rd_exp_t   r;
    done_exp_t d;
    prev_pop = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_pop = 1'b0;
      end else begin
        if (prev_pop) begin
          if (exp_cpu.size() == 0) flag("cpu_rd_unexpected");
          else begin
            r = exp_cpu.pop_front();
            if (r.care) chk("cpu_rdata", bus.stk_rdata, r.data);
          end
        end
        prev_pop = bus.stk_pop & ~bus.ctx_busy;
        if (bus.ctx_rd_valid) begin
          if (exp_rd.size() == 0) flag("ctx_rd_unexpected");
          else begin
            r = exp_rd.pop_front();
            if (r.care) chk("ctx_rdata", bus.stk_rdata, r.data);
          end
        end
        if (bus.ctx_done) begin
          if (exp_done.size() == 0) flag("ctx_done_unexpected");
          else begin
            d = exp_done.pop_front();
            chk1("done_wr_rdy", bus.ctx_wr_rdy, d.wr);
            chk1("done_rd_valid", bus.ctx_rd_valid, d.rd);
`ifdef STACK_PROT_EN
            chk1("done_ctx_err", bus.ctx_err, d.err);
`endif
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    exp_rd.delete();
    exp_cpu.delete();
    exp_done.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic cpu_op(input bit push, input bit pop, input logic [31:0] d, output int stalls);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    bus.cpu_push  = push;
    bus.cpu_pop   = pop;
    bus.cpu_wdata = d;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin ok = 1'b1; break; end
      stalls++;
      @(posedge clk);
      #1;
    end
    if (!ok) flag("cpu_op_timeout");
    else if (push) begin
      if (model.size() < DEPTH) model.push_back(d);
    end else if (pop) begin
      if (model.size() > 0) exp_cpu.push_back('{1'b1, model.pop_back()});
`ifdef STACK_PROT_EN
      else exp_unf = 1'b1;
`else
      else exp_cpu.push_back('{1'b0, 32'd0});
`endif
    end
    @(posedge clk);
    #1;
    bus.cpu_push = 1'b0;
    bus.cpu_pop  = 1'b0;
  endtask

  task automatic ctx_burst(input bit save, input int len, input logic [31:0] base, input bit rnd);
    logic [31:0] w [8];
    int lc, room, n, exp_wr, exp_pops, wr_cnt, pop_cnt, idx;
    bit ok, adv;
    lc = (len > 8) ? 8 : len;
    for (int i = 0; i < 8; i++) w[i] = rnd ? $urandom : base + i;
    exp_wr = 0;
    exp_pops = 0;
    if (save) begin
      room = DEPTH - model.size();
      n = (lc < room) ? lc : room;
      for (int i = 0; i < n; i++) model.push_back(w[i]);
`ifdef STACK_PROT_EN
      exp_wr = n;
      if (lc > room) begin
        exp_ovf = 1'b1;
        exp_done.push_back('{1'b0, 1'b0, 1'b1});
      end else exp_done.push_back('{lc > 0, 1'b0, 1'b0});
`else
      exp_wr = lc;
      exp_done.push_back('{lc > 0, 1'b0, 1'b0});
`endif
    end else begin
`ifdef STACK_PROT_EN
      if (lc > model.size()) begin
        exp_unf = 1'b1;
        exp_done.push_back('{1'b0, 1'b0, 1'b1});
        lc = 0;
      end else
`endif
      exp_done.push_back('{1'b0, lc > 0, 1'b0});
      exp_pops = lc;
      for (int i = 0; i < lc; i++) begin
        if (model.size() > 0) exp_rd.push_back('{1'b1, model.pop_back()});
        else exp_rd.push_back('{1'b0, 32'd0});
      end
    end
    bus.ctx_req   = 1'b1;
    bus.ctx_save  = save;
    bus.ctx_len   = 4'(len);
    bus.ctx_wdata = w[0];
    @(posedge clk);
    #1;
    bus.ctx_req = 1'b0;
    wr_cnt = 0;
    pop_cnt = 0;
    idx = 0;
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      adv = bus.ctx_wr_rdy;
      if (bus.ctx_wr_rdy) wr_cnt++;
      if (bus.stk_pop) pop_cnt++;
      if (!bus.ctx_busy) begin ok = 1'b1; break; end
      @(posedge clk);
      #1;
      if (adv && idx < 7) begin
        idx++;
        bus.ctx_wdata = w[idx];
      end
    end
    if (!ok) flag("burst_timeout");
    @(posedge clk);
    #1;
    chk("burst_wr_cnt", wr_cnt, exp_wr);
    chk("burst_pop_cnt", pop_cnt, exp_pops);
    chk("burst_depth", 32'(bus.depth), model.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, op;
    bus.cpu_push = 0; bus.cpu_pop = 0; bus.cpu_wdata = '0;
    bus.ctx_req = 0; bus.ctx_save = 0; bus.ctx_len = '0; bus.ctx_wdata = '0;
    do_reset();

    chk("rst_depth", 32'(bus.depth), 0);
    chk1("rst_empty", bus.empty, 1'b1);
    chk1("rst_full", bus.full, 1'b0);
    chk1("rst_busy", bus.ctx_busy, 1'b0);
    chk1("rst_done", bus.ctx_done, 1'b0);
    chk1("rst_stk_push", bus.stk_push, 1'b0);
    chk1("rst_rd_valid", bus.ctx_rd_valid, 1'b0);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
`ifdef STACK_PROT_EN
    chk1("rst_err_ovf", bus.err_ovf, 1'b0);
    chk1("rst_err_unf", bus.err_unf, 1'b0);
`endif

    cpu_op(1, 0, 32'hA, st);
    cpu_op(1, 0, 32'hB, st);
    cpu_op(1, 0, 32'hC, st);
    cpu_op(0, 1, 32'h0, st);
    chk("cpu_depth2", 32'(bus.depth), 2);

    ctx_burst(1, 4, 32'h10, 1'b0);
    chk("save4_depth", 32'(bus.depth), 6);
    ctx_burst(0, 4, 32'h0, 1'b0);

    fork
      ctx_burst(1, 3, 32'h100, 1'b0);
      begin
        cpu_op(1, 0, 32'h55, st);
        chk("stall_cycles", st, 4);
      end
    join
    chk("stall_depth", 32'(bus.depth), 6);

    ctx_burst(1, 0, 32'h0, 1'b0);
    ctx_burst(1, 13, 32'h200, 1'b0);
    ctx_burst(0, 15, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 5);
      case (op)
        0, 1: cpu_op(1, 0, $urandom, st);
        2:    cpu_op(0, 1, 32'h0, st);
        3:    cpu_op(1, 1, $urandom, st);
        4:    ctx_burst(1, $urandom_range(0, 15), 32'h0, 1'b1);
        default: ctx_burst(0, $urandom_range(0, 15), 32'h0, 1'b0);
      endcase
      chk("rand_depth", 32'(bus.depth), model.size());
    end

    bus.ctx_req = 1'b1; bus.ctx_save = 1'b1; bus.ctx_len = 4'd8; bus.ctx_wdata = 32'h77;
    @(posedge clk); #1;
    bus.ctx_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("rstmid_no_done", bus.ctx_done, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model.delete(); exp_rd.delete(); exp_cpu.delete(); exp_done.delete();
    exp_ovf = 1'b0; exp_unf = 1'b0;
    @(negedge clk);
    chk1("rstmid_busy", bus.ctx_busy, 1'b0);
    chk("rstmid_depth", 32'(bus.depth), 0);
    chk1("rstmid_done", bus.ctx_done, 1'b0);
    @(posedge clk); #1;

    bus.cpu_pop = 1'b1;
    @(negedge clk);
`ifdef STACK_PROT_EN
    chk1("pop_empty_stk_pop", bus.stk_pop, 1'b0);
`else
    chk1("pop_empty_stk_pop", bus.stk_pop, 1'b1);
    exp_cpu.push_back('{1'b0, 32'd0});
`endif
    @(posedge clk); #1;
    bus.cpu_pop = 1'b0;
    chk("pop_empty_depth", 32'(bus.depth), 0);
`ifdef STACK_PROT_EN
    chk1("pop_empty_err_unf", bus.err_unf, 1'b1);
`endif
    @(posedge clk); #1;
    do_reset();
    cpu_op(1, 0, 32'h99, st);
    ctx_burst(0, 3, 32'h0, 1'b0);
    chk("restore3_depth", 32'(bus.depth), model.size());
`ifdef STACK_PROT_EN
    chk1("restore3_err_unf", bus.err_unf, exp_unf);
`endif

    while (model.size() < DEPTH)
      ctx_burst(1, ((DEPTH - model.size()) < 8) ? (DEPTH - model.size()) : 8, 32'h0, 1'b1);
    chk1("fill_full", bus.full, 1'b1);
    chk("fill_depth", 32'(bus.depth), DEPTH);

    bus.cpu_push = 1'b1; bus.cpu_wdata = 32'hDEAD;
    @(negedge clk);
`ifdef STACK_PROT_EN
    chk1("full_push_stall", bus.cpu_stall, 1'b1);
    chk1("full_push_stk_push", bus.stk_push, 1'b0);
`else
    chk1("full_push_stall", bus.cpu_stall, 1'b0);
    chk1("full_push_stk_push", bus.stk_push, 1'b1);
`endif
    @(posedge clk); #1;
    bus.cpu_push = 1'b0;
    chk("full_push_depth", 32'(bus.depth), DEPTH);
    chk1("full_push_full", bus.full, 1'b1);
`ifdef STACK_PROT_EN
    chk1("full_push_err_ovf", bus.err_ovf, 1'b1);
`endif
    ctx_burst(1, 2, 32'h300, 1'b0);
    ctx_burst(0, 8, 32'h0, 1'b0);
    chk("final_depth", 32'(bus.depth), DEPTH - 8);

    repeat (3) @(posedge clk);
    #1;
    chk("leftover_rd", exp_rd.size(), 0);
    chk("leftover_cpu", exp_cpu.size(), 0);
    chk("leftover_done", exp_done.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
